param_sync_fifo: RTL and testbench
==================================

Name: param_sync_fifo

Overview:
- Parametrised single-clock synchronous FIFO. Next generation of the team's simple 16x8 FIFO controller.
- Width, depth and almost-full/almost-empty thresholds are configurable.
- Read data is registered and qualified by a valid strobe. Reads and writes in the same cycle are handled correctly at every fill level. Sticky overflow/underflow error flags are provided.
- Used wherever an IP needs elastic buffering between producer and consumer logic in one clock domain.

Parameters:
- WIDTH, 8, data width in bits (>=1).
- DEPTH, 16, number of entries. Power of two, >=4.
- AFULL_TH, DEPTH-2, almost_full asserts when count >= AFULL_TH.
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- data_in  in  WIDTH  write data.
- wr_en  in  1  write request.
- rd_en  in  1  read request.
- clr_err  in  1  clears the sticky error flags.
- data_out  out  WIDTH  read data, registered.
- rd_valid  out  1  data_out holds the word from the read accepted last cycle.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AFULL_TH.
- almost_empty  out  1  count <= AEMPTY_TH.
- count  out  AW+1  current occupancy, where AW = clog2(DEPTH).
- overflow  out  1  sticky: a write was rejected.
- underflow  out  1  sticky: a read was rejected.

Behaviour:
- All state updates on the rising edge of clk. rst is sampled on the edge and overrides everything else.
- Reset values:
  - wr_ptr = rd_ptr = 0, count = 0.
  - data_out = 0, rd_valid = 0, overflow = underflow = 0.
  - empty = 1, full = 0, almost_empty = 1, almost_full = 0.
  - Memory contents are not reset.
- Read accept: rd_acc = rd_en && !empty. There is no write-to-read bypass: a read when empty is rejected even if wr_en is high in the same cycle.
- Write accept: wr_acc = wr_en && (!full || rd_acc). When full, a simultaneous read frees a slot, so both are accepted and count stays at DEPTH.
- Count update: count <= count + wr_acc - rd_acc. Both accepted -> count unchanged. Never exceeds DEPTH, never goes below 0.
- Pointers: AW bits each, wrap from DEPTH-1 to 0 naturally. wr_ptr advances on wr_acc, rd_ptr advances on rd_acc.
- Write: mem[wr_ptr] <= data_in on wr_acc.
- Read latency is 1 cycle:
  - On rd_acc: data_out <= mem[rd_ptr] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and data_out holds its value.
- Simultaneous read and write at the same address (possible only at full) returns the old word.
- Flags (full, empty, almost_full, almost_empty) are decoded combinationally from the registered count, so they are valid the cycle after the access that changed count.
- Errors:
  - overflow <= 1 when wr_en && !wr_acc.
  - underflow <= 1 when rd_en && !rd_acc.
  - clr_err clears both flags next cycle. A new error in the same cycle as clr_err wins (flag set).
- A rejected access has no effect on pointers, count or memory.
- Reset mid-operation discards all contents. A read accepted in the cycle before reset still gets rd_valid = 0 after reset.
- Elaboration checks: DEPTH must be a power of two, and AEMPTY_TH < AFULL_TH <= DEPTH. Otherwise issue a fatal error.

Decomposition:
- Shared package fifo_pkg:
  - clog2 function.
  - Localparam helper for count width (AW+1).
  - Common error-flag bit positions for IP status registers.
- One sub-module is natural: fifo_ram (WIDTH x DEPTH, one write port, one registered read port, no reset). The controller instantiates it and keeps pointers, count, flags and errors.

Test Plan (WIDTH=8, DEPTH=16, AFULL_TH=14, AEMPTY_TH=2):
- Reset then idle -> empty=1, almost_empty=1, count=0, rd_valid=0, data_out=0, overflow=underflow=0.
- Write 0x00..0x0F on 16 consecutive cycles -> full=1 after the 16th write, almost_full first seen after the 14th write. Then 16 reads -> data_out 0x00..0x0F in order, each 1 cycle after its rd_en with rd_valid=1, empty=1 at end.
- Fill to 16, then wr_en=rd_en=1 with 0xA5 -> count stays 16, data_out=0x00, 0xA5 read last. A 17th write without read -> rejected, overflow=1.
- Empty FIFO, wr_en=rd_en=1 with 0x3C -> read rejected, underflow=1, count=1, rd_valid=0. Next cycle, read -> data_out=0x3C.
- Steady streaming of 40 words at count=5 (both enables high) -> count constant 5, pointers wrap twice, output order preserved. clr_err pulse -> errors cleared.
- Fill to 9, assert rst for 1 cycle while rd_en=1 -> count=0, empty=1, rd_valid=0 next cycle, no stale data on the subsequent read attempt (underflow=1).

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the synchronous FIFO family: sizing helpers and the
// error-flag layout used when the flags are exported to IP status registers.
package fifo_pkg;

    // Ceiling log2; clog2(1) == 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned v;
        int unsigned r;
        v = (value > 0) ? value - 1 : 0;
        r = 0;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Occupancy counter width: one extra bit so DEPTH itself is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return clog2(depth) + 1;
    endfunction

    function automatic bit is_pow2(input int unsigned value);
        return (value != 0) && ((value & (value - 1)) == 0);
    endfunction

    localparam int unsigned ERR_OVERFLOW_BIT  = 0;
    localparam int unsigned ERR_UNDERFLOW_BIT = 1;
    localparam int unsigned ERR_NUM_BITS      = 2;

    // Field order matches the bit positions above.
    typedef struct packed {
        logic underflow;
        logic overflow;
    } fifo_err_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage: one write port, one registered read port, no reset.
// A read and write to the same address in one cycle returns the old word.
module fifo_ram
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned AW   = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO controller: pointers, occupancy, status flags
// and sticky error flags around a fifo_ram with one cycle of read latency.
module param_sync_fifo
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AFULL_TH  = DEPTH - 2,
    parameter int unsigned AEMPTY_TH = 2,
    localparam int unsigned AW       = clog2(DEPTH),
    localparam int unsigned CW       = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             wr_en,
    input  logic             rd_en,
    input  logic             clr_err,
    output logic [WIDTH-1:0] data_out,
    output logic             rd_valid,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    if (WIDTH < 1) begin : g_bad_width
        $fatal(1, "param_sync_fifo: WIDTH must be >= 1");
    end
    if (!is_pow2(DEPTH) || DEPTH < 4) begin : g_bad_depth
        $fatal(1, "param_sync_fifo: DEPTH must be a power of two >= 4");
    end
    if (!(AEMPTY_TH < AFULL_TH && AFULL_TH <= DEPTH)) begin : g_bad_thresholds
        $fatal(1, "param_sync_fifo: need AEMPTY_TH < AFULL_TH <= DEPTH");
    end

    localparam logic [CW-1:0] DepthC  = CW'(DEPTH);
    localparam logic [CW-1:0] AfullC  = CW'(AFULL_TH);
    localparam logic [CW-1:0] AemptyC = CW'(AEMPTY_TH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             rd_valid_q, rd_valid_d;
    logic             dout_live_q, dout_live_d;
    fifo_err_t        err_q, err_d;
    logic             rd_acc, wr_acc;
    logic [WIDTH-1:0] ram_rd_data;

    // Flags come straight from the registered count.
    assign full         = (count_q == DepthC);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AfullC);
    assign almost_empty = (count_q <= AemptyC);

    always_comb begin
        rd_acc      = rd_en && !empty;
        // A read at full frees the slot this write lands in.
        wr_acc      = wr_en && (!full || rd_acc);

        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_valid_d  = rd_acc;
        dout_live_d = dout_live_q || rd_acc;
        err_d       = err_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh error in the same cycle as clr_err keeps the flag set.
        err_d.overflow  = (wr_en && !wr_acc) || (err_q.overflow && !clr_err);
        err_d.underflow = (rd_en && !rd_acc) || (err_q.underflow && !clr_err);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_valid_q  <= 1'b0;
            dout_live_q <= 1'b0;
            err_q       <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_valid_q  <= rd_valid_d;
            dout_live_q <= dout_live_d;
            err_q       <= err_d;
        end
    end

    fifo_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (wr_acc && !rst),
        .wr_addr (wr_ptr_q),
        .wr_data (data_in),
        .rd_en   (rd_acc && !rst),
        .rd_addr (rd_ptr_q),
        .rd_data (ram_rd_data)
    );

    // The RAM read register has no reset; mask it until the first read after reset.
    assign data_out  = dout_live_q ? ram_rd_data : '0;
    assign rd_valid  = rd_valid_q;
    assign count     = count_q;
    assign overflow  = err_q.overflow;
    assign underflow = err_q.underflow;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Self-checking bench for param_sync_fifo: directed scenarios plus random
// traffic, all compared every cycle against a queue-based reference model.
module tb_param_sync_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AFT   = 14;
    localparam int unsigned AET   = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             wr_en, rd_en, clr_err;
    logic [WIDTH-1:0] data_out;
    logic             rd_valid, full, empty, almost_full, almost_empty;
    logic [4:0]       count;
    logic             overflow, underflow;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [WIDTH-1:0] q [$];
    logic [WIDTH-1:0] m_dout;
    logic             m_valid, m_ovf, m_unf;

    always #5 clk = ~clk;

    param_sync_fifo #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFT),
        .AEMPTY_TH (AET)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .clr_err      (clr_err),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string where);
        int n;
        n = q.size();
        chk({where, ":count"},    32'(count),        32'(n));
        chk({where, ":empty"},    32'(empty),        32'(n == 0));
        chk({where, ":full"},     32'(full),         32'(n == DEPTH));
        chk({where, ":afull"},    32'(almost_full),  32'(n >= AFT));
        chk({where, ":aempty"},   32'(almost_empty), 32'(n <= AET));
        chk({where, ":rd_valid"}, 32'(rd_valid),     32'(m_valid));
        chk({where, ":data_out"}, 32'(data_out),     32'(m_dout));
        chk({where, ":overflow"}, 32'(overflow),     32'(m_ovf));
        chk({where, ":underflow"},32'(underflow),    32'(m_unf));
    endtask

    // One clock: drive inputs, advance the model by the FIFO rules, compare.
    task automatic step(input string where, input logic w, input logic r,
                        input logic [WIDTH-1:0] d, input logic c, input logic rs);
        logic racc, wacc;
        wr_en   = w;
        rd_en   = r;
        data_in = d;
        clr_err = c;
        rst     = rs;
        if (rs) begin
            q.delete();
            m_valid = 1'b0;
            m_dout  = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
        end else begin
            racc = r && (q.size() > 0);
            wacc = w && ((q.size() < DEPTH) || racc);
            if (racc) begin
                m_dout = q.pop_front();
            end
            m_valid = racc;
            if (wacc) begin
                q.push_back(d);
            end
            m_ovf = (w && !wacc) ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_unf = (r && !racc) ? 1'b1 : (c ? 1'b0 : m_unf);
        end
        @(posedge clk);
        #1;
        check_all(where);
    endtask

    initial begin
        logic w, r, c, rs;
        wr_en = 0; rd_en = 0; clr_err = 0; data_in = '0; rst = 1;
        m_dout = '0; m_valid = 0; m_ovf = 0; m_unf = 0;
        #2;

        // Reset then idle
        step("reset0", 0, 0, 8'h00, 0, 1);
        step("reset1", 0, 0, 8'h00, 0, 1);
        step("idle", 0, 0, 8'h00, 0, 0);

        // Fill 0x00..0x0F then drain in order
        for (int i = 0; i < 16; i++) step("fill", 1, 0, 8'(i), 0, 0);
        chk("full_after_16", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step("drain", 0, 1, 8'h00, 0, 0);
            chk("drain_order", 32'(data_out), 32'(i));
        end
        chk("empty_after_drain", 32'(empty), 32'd1);

        // Full with simultaneous read/write, then overflow
        for (int i = 0; i < 16; i++) step("fill2", 1, 0, 8'(i), 0, 0);
        step("full_rw", 1, 1, 8'hA5, 0, 0);
        chk("full_rw_dout", 32'(data_out), 32'h00);
        step("overflow", 1, 0, 8'h5A, 0, 0);
        chk("overflow_set", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) step("drain2", 0, 1, 8'h00, 0, 0);
        chk("a5_last", 32'(data_out), 32'hA5);

        // Empty with simultaneous read/write: no bypass
        step("clr1", 0, 0, 8'h00, 1, 0);
        step("empty_rw", 1, 1, 8'h3C, 0, 0);
        chk("underflow_set", 32'(underflow), 32'd1);
        step("read_3c", 0, 1, 8'h00, 0, 0);
        chk("dout_3c", 32'(data_out), 32'h3C);

        // Streaming at count 5 with pointer wrap
        for (int i = 0; i < 5; i++) step("pre5", 1, 0, 8'($urandom), 0, 0);
        for (int i = 0; i < 40; i++) step("stream", 1, 1, 8'($urandom), 0, 0);
        chk("stream_count", 32'(count), 32'd5);
        step("clr2", 0, 0, 8'h00, 1, 0);
        chk("clr_ovf", 32'(overflow), 32'd0);
        chk("clr_unf", 32'(underflow), 32'd0);
        // Error in the same cycle as clr_err wins
        for (int i = 0; i < 5; i++) step("post5", 0, 1, 8'h00, 0, 0);
        step("clr_vs_err", 0, 1, 8'h00, 1, 0);

        // Reset mid-operation while reading
        for (int i = 0; i < 9; i++) step("pre9", 1, 0, 8'($urandom), 0, 0);
        step("mid_reset", 0, 1, 8'h00, 0, 1);
        step("after_reset", 0, 1, 8'h00, 0, 0);
        chk("after_reset_unf", 32'(underflow), 32'd1);

        // Random traffic: write-biased, then read-biased
        for (int i = 0; i < 600; i++) begin
            if (i < 300) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            c  = ($urandom_range(0, 15) == 0);
            rs = ($urandom_range(0, 127) == 0);
            step("random", w, r, 8'($urandom), c, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
